// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one off-chip memory port between two cache controllers.
// Writes broadcast an invalidate of the written address to the non-owning cache.
module memory_arbiter #(
    parameter int REQ_WIDTH  = 25,
    parameter int ADDR_WIDTH = 16,
    parameter int RESP_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REQ_WIDTH-1:0]  memory_request_0,
    input  logic [REQ_WIDTH-1:0]  memory_request_1,
    input  logic                  memory_request_ready_0,
    input  logic                  memory_request_ready_1,
    output logic [RESP_WIDTH-1:0] memory_response_0,
    output logic [RESP_WIDTH-1:0] memory_response_1,
    output logic                  memory_response_ready_0,
    output logic                  memory_response_ready_1,
    output logic [REQ_WIDTH-1:0]  mem_request,
    output logic                  mem_request_valid,
    input  logic [RESP_WIDTH-1:0] mem_response,
    input  logic                  mem_response_valid,
    output logic [ADDR_WIDTH-1:0] invalidate_address,
    output logic                  invalidate_valid_0,
    output logic                  invalidate_valid_1,
    output logic                  grant,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t                state_q, state_d;
    logic [REQ_WIDTH-1:0]  mem_request_q, mem_request_d;
    logic                  mem_request_valid_q, mem_request_valid_d;
    logic [ADDR_WIDTH-1:0] invalidate_address_q, invalidate_address_d;
    logic                  invalidate_valid_0_q, invalidate_valid_0_d;
    logic                  invalidate_valid_1_q, invalidate_valid_1_d;
    logic [RESP_WIDTH-1:0] memory_response_0_q, memory_response_0_d;
    logic [RESP_WIDTH-1:0] memory_response_1_q, memory_response_1_d;
    logic                  memory_response_ready_0_q, memory_response_ready_0_d;
    logic                  memory_response_ready_1_q, memory_response_ready_1_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  served_0_q, served_0_d;
    logic                  served_1_q, served_1_d;
    logic                  busy_q, busy_d;

    logic                  eligible_0, eligible_1;
    logic                  grant_sel;
    logic [REQ_WIDTH-1:0]  sel_request;

    // A ready still held after its response must not be serviced a second time.
    assign eligible_0 = memory_request_ready_0 & ~served_0_q;
    assign eligible_1 = memory_request_ready_1 & ~served_1_q;

    always_comb begin
        state_d                   = state_q;
        mem_request_d             = mem_request_q;
        mem_request_valid_d       = 1'b0;
        invalidate_address_d      = invalidate_address_q;
        invalidate_valid_0_d      = 1'b0;
        invalidate_valid_1_d      = 1'b0;
        memory_response_0_d       = memory_response_0_q;
        memory_response_1_d       = memory_response_1_q;
        memory_response_ready_0_d = 1'b0;
        memory_response_ready_1_d = 1'b0;
        grant_d                   = grant_q;
        last_grant_d              = last_grant_q;
        served_0_d                = served_0_q & memory_request_ready_0;
        served_1_d                = served_1_q & memory_request_ready_1;
        grant_sel                 = (eligible_0 && eligible_1) ? ~last_grant_q : eligible_1;
        sel_request               = grant_sel ? memory_request_1 : memory_request_0;

        case (state_q)
            IDLE: begin
                if (eligible_0 || eligible_1) begin
                    state_d             = ISSUE;
                    mem_request_d       = sel_request;
                    mem_request_valid_d = 1'b1;
                    grant_d             = grant_sel;
                    last_grant_d        = grant_sel;
                    if (sel_request[REQ_WIDTH-1]) begin
                        invalidate_address_d = sel_request[ADDR_WIDTH-1:0];
                        invalidate_valid_0_d = grant_sel;
                        invalidate_valid_1_d = ~grant_sel;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mem_response_valid) begin
                    state_d = RESPOND;
                    if (grant_q) begin
                        memory_response_1_d       = mem_response;
                        memory_response_ready_1_d = 1'b1;
                        served_1_d                = 1'b1;
                    end else begin
                        memory_response_0_d       = mem_response;
                        memory_response_ready_0_d = 1'b1;
                        served_0_d                = 1'b1;
                    end
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // last_grant resets to 1 so that cache 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q                   <= IDLE;
            mem_request_q             <= '0;
            mem_request_valid_q       <= 1'b0;
            invalidate_address_q      <= '0;
            invalidate_valid_0_q      <= 1'b0;
            invalidate_valid_1_q      <= 1'b0;
            memory_response_0_q       <= '0;
            memory_response_1_q       <= '0;
            memory_response_ready_0_q <= 1'b0;
            memory_response_ready_1_q <= 1'b0;
            grant_q                   <= 1'b0;
            last_grant_q              <= 1'b1;
            served_0_q                <= 1'b0;
            served_1_q                <= 1'b0;
            busy_q                    <= 1'b0;
        end else begin
            state_q                   <= state_d;
            mem_request_q             <= mem_request_d;
            mem_request_valid_q       <= mem_request_valid_d;
            invalidate_address_q      <= invalidate_address_d;
            invalidate_valid_0_q      <= invalidate_valid_0_d;
            invalidate_valid_1_q      <= invalidate_valid_1_d;
            memory_response_0_q       <= memory_response_0_d;
            memory_response_1_q       <= memory_response_1_d;
            memory_response_ready_0_q <= memory_response_ready_0_d;
            memory_response_ready_1_q <= memory_response_ready_1_d;
            grant_q                   <= grant_d;
            last_grant_q              <= last_grant_d;
            served_0_q                <= served_0_d;
            served_1_q                <= served_1_d;
            busy_q                    <= busy_d;
        end
    end

    assign mem_request             = mem_request_q;
    assign mem_request_valid       = mem_request_valid_q;
    assign invalidate_address      = invalidate_address_q;
    assign invalidate_valid_0      = invalidate_valid_0_q;
    assign invalidate_valid_1      = invalidate_valid_1_q;
    assign memory_response_0       = memory_response_0_q;
    assign memory_response_1       = memory_response_1_q;
    assign memory_response_ready_0 = memory_response_ready_0_q;
    assign memory_response_ready_1 = memory_response_ready_1_q;
    assign grant                   = grant_q;
    assign busy                    = busy_q;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single off-chip memory port between the two cache controllers (cache 0 and cache 1) of the dual-CPU cache. Each cache presents a 25-bit memory request `{write, data[7:0], address[15:0]}` (parallel side, after deserialization). The arbiter grants one request at a time with round-robin priority, forwards it to memory, and routes the 16-bit line response back to the owner. On every write it pulses an invalidate with the address to the other cache, so no stale copy survives.

## Interface
- `REQ_WIDTH`, 25, request word width `{write, data, address}`
- `ADDR_WIDTH`, 16, address field width (request bits `[ADDR_WIDTH-1:0]`)
- `RESP_WIDTH`, 16, memory response (one 2-byte line) width
- `clock`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clock`
- `memory_request_0` / `memory_request_1`  in  REQ_WIDTH  request word from cache 0 / 1
- `memory_request_ready_0` / `memory_request_ready_1`  in  1  level; held high by the cache until its response pulse
- `memory_response_0` / `memory_response_1`  out  RESP_WIDTH  line data returned to cache 0 / 1
- `memory_response_ready_0` / `memory_response_ready_1`  out  1  one-cycle pulse; response valid
- `mem_request`  out  REQ_WIDTH  latched request forwarded to memory
- `mem_request_valid`  out  1  one-cycle pulse; `mem_request` issued
- `mem_response`  in  RESP_WIDTH  memory line data
- `mem_response_valid`  in  1  memory response strobe
- `invalidate_address`  out  ADDR_WIDTH  address of a write being issued
- `invalidate_valid_0` / `invalidate_valid_1`  out  1  one-cycle pulse; invalidate the line in cache 0 / 1
- `grant`  out  1  index of current or most recent owner
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- Eligibility:
  - `eligible_k = memory_request_ready_k & ~served_k`.
  - `served_k` is set when RESPOND pulses port k.
  - `served_k` is cleared on any edge where `memory_request_ready_k` is sampled low.
  - This prevents a held ready from being serviced twice.
- IDLE:
  - If neither port is eligible, stay.
  - If one port is eligible, grant it.
  - If both are eligible, grant `~last_grant`.
  - On grant: latch `memory_request_k` into `mem_request`, set `grant = k`, set `last_grant = k`, go to ISSUE.
- ISSUE (1 cycle):
  - `mem_request_valid = 1`.
  - If write bit (`mem_request[REQ_WIDTH-1]`) is 1: `invalidate_valid_{~grant} = 1`, and `invalidate_address = mem_request[ADDR_WIDTH-1:0]`.
  - Go to WAIT.
- WAIT:
  - Stay until `mem_response_valid` is sampled high.
  - Then register `mem_response` into `memory_response_{grant}` and go to RESPOND.
- RESPOND (1 cycle):
  - `memory_response_ready_{grant} = 1`, `served_{grant} = 1`.
  - Go to IDLE.
- `mem_response_valid` is ignored outside WAIT, including during the ISSUE cycle.
- `mem_request` and `invalidate_address` hold their values until the next grant.
- `memory_response_k` holds until the next response to port k; the other port's response register is never disturbed.
- Requests are not re-sampled after the grant; a cache changing `memory_request_k` mid-transaction has no effect.
- A cache dropping ready mid-transaction does not abort it; the response still pulses.

## Timing
- Reset state: IDLE, `last_grant = 1` (cache 0 wins the first tie), `served_0 = served_1 = 0`.
- All outputs are 0 after reset: `mem_request`, `memory_response_k`, `invalidate_address`, `grant`, every valid/ready pulse, and `busy`.
- Reset mid-transaction abandons the transaction: no response pulse, no pending invalidate.
- Eligible request sampled at edge E0 (in IDLE) → `mem_request_valid` high in cycle E0..E0+1.
- `mem_response_valid` sampled at edge E1 (in WAIT) → `memory_response_ready_k` high in cycle E1..E1+1.
- Minimum turnaround is 4 cycles per transaction: IDLE, ISSUE, WAIT (response in first WAIT cycle), RESPOND.
- Back-to-back transactions:
  - A port pending during another's transaction is granted at the first IDLE edge after RESPOND.
  - There is no idle gap beyond that IDLE cycle.
- Invalidate pulses are coincident with `mem_request_valid`; reads never invalidate.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then cache 0 read `{0,8'h00,16'h0016}`:
  - `mem_request = 25'h0000016`, valid is a 1-cycle pulse, no invalidate.
  - Memory returns `16'h1017` 3 cycles later.
  - `memory_response_0 = 16'h1017` with a 1-cycle ready pulse; port 1 untouched.
- Cache 1 write `{1,8'h19,16'h0017}`:
  - `invalidate_valid_0` pulses with `invalidate_address = 16'h0017` in the same cycle as `mem_request_valid`.
  - `invalidate_valid_1` stays 0.
- Both ready in the same cycle after reset:
  - Cache 0 is served first, then cache 1 with no extra idle.
  - Next simultaneous pair: cache 0 first again (last grant was 1).
- Cache 0 holds ready for 5 cycles after its response pulse:
  - No second `mem_request_valid`.
  - After ready drops 1 cycle and rises again, a new transaction starts.
- `mem_response_valid` pulsed during ISSUE and while IDLE is ignored; only a WAIT-state strobe completes the transaction.
- `reset` asserted during WAIT:
  - Next cycle: IDLE, all outputs 0, no response pulse.
  - A late `mem_response_valid` is ignored.
  - Pending requests are re-arbitrated with cache 0 winning the tie.
